// File: rtl/selector_scan_pkg.sv
// Shared definitions for the channel selector/scanner: FSM encoding and index-width helper.
package selector_scan_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/selector_dwell_cnt.sv
// Dwell counter: counts 0..DIV-1 while enabled, synchronous clear, combinational wrap pulse.
module selector_dwell_cnt
    import selector_scan_pkg::*;
#(
    parameter int DIV = 4,
    localparam int CNT_W = sel_width(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    logic [CNT_W-1:0] count_reg;

    assign wrap = en && (count_reg == CNT_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= wrap ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/selector_scan.sv
// Channel selector with manual selection and timed auto-scan; output data and index are registered together.
module selector_scan
    import selector_scan_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DIV      = 4,
    localparam int SEL_W   = sel_width(CHANNELS)
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [CHANNELS*WIDTH-1:0] iData,
    input  logic [SEL_W-1:0]          iSel,
    input  logic                      iMode,
    input  logic                      iEn,
    output logic [WIDTH-1:0]          oZ,
    output logic [SEL_W-1:0]          oCh,
    output logic                      oStep,
    output logic                      oValid
);

    state_t           state_reg;
    logic [SEL_W-1:0] ch_reg;
    logic [SEL_W-1:0] ch_next;
    logic [WIDTH-1:0] z_reg;
    logic             step_reg;
    logic             step_next;
    logic             valid_reg;
    logic             scanning;
    logic             sel_ok;
    logic             cnt_wrap;
    logic [SEL_W-1:0] ch_inc;
    logic [WIDTH-1:0] chan [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign chan[gi] = iData[gi*WIDTH +: WIDTH];
    end

    // Scanning only while already in SCAN and staying there; a mode change pre-empts any wrap.
    assign scanning = (state_reg == SCAN) && iMode;
    assign sel_ok   = {1'b0, iSel} < (SEL_W + 1)'(CHANNELS);
    assign ch_inc   = (ch_reg == SEL_W'(CHANNELS - 1)) ? '0 : ch_reg + 1'b1;

    selector_dwell_cnt #(
        .DIV (DIV)
    ) u_dwell (
        .clk  (iClk),
        .rst  (iRst),
        .en   (scanning && iEn),
        .clr  (!scanning),
        .wrap (cnt_wrap)
    );

    always_comb begin
        ch_next   = ch_reg;
        step_next = 1'b0;
        if (!iMode) begin
            // Manual and SCAN->MANUAL both take iSel; out-of-range indices are ignored.
            if (sel_ok) begin
                ch_next = iSel;
            end
        end else if (scanning && cnt_wrap) begin
            ch_next   = ch_inc;
            step_next = 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_reg <= MANUAL;
            ch_reg    <= '0;
            z_reg     <= '0;
            step_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= iMode ? SCAN : MANUAL;
            ch_reg    <= ch_next;
            z_reg     <= chan[ch_next];
            step_reg  <= step_next;
            valid_reg <= 1'b1;
        end
    end

    assign oZ     = z_reg;
    assign oCh    = ch_reg;
    assign oStep  = step_reg;
    assign oValid = valid_reg;

endmodule

// File: tb/tb_selector_scan.sv
// Directed bench: 4-channel/DIV=4 instance for the main flows, 3-channel/DIV=1 instance for wrap and range cases.
module tb_selector_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 4 channels, DIV=4
    logic        rst;
    logic [15:0] data;
    logic [1:0]  sel;
    logic        mode, en;
    logic [3:0]  z;
    logic [1:0]  ch;
    logic        step, valid;

    // 3 channels, DIV=1
    logic        rst3;
    logic [11:0] data3;
    logic [1:0]  sel3;
    logic        mode3, en3;
    logic [3:0]  z3;
    logic [1:0]  ch3;
    logic        step3, valid3;

    int checks = 0;
    int errors = 0;

    selector_scan #(.WIDTH(4), .CHANNELS(4), .DIV(4)) dut (
        .iClk(clk), .iRst(rst), .iData(data), .iSel(sel), .iMode(mode), .iEn(en),
        .oZ(z), .oCh(ch), .oStep(step), .oValid(valid)
    );

    selector_scan #(.WIDTH(4), .CHANNELS(3), .DIV(1)) dut3 (
        .iClk(clk), .iRst(rst3), .iData(data3), .iSel(sel3), .iMode(mode3), .iEn(en3),
        .oZ(z3), .oCh(ch3), .oStep(step3), .oValid(valid3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int exp_ch [13]   = '{2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1};
    int exp_st [13]   = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_z  [13]   = '{'hC, 'hC, 'hC, 'hC, 'hD, 'hD, 'hD, 'hD, 'hA, 'hA, 'hA, 'hA, 'hB};
    int exp_ch3 [5]   = '{0, 1, 2, 0, 1};
    int exp_st3 [5]   = '{0, 1, 1, 1, 1};
    int exp_z3  [5]   = '{1, 2, 3, 1, 2};

    initial begin
        rst  = 1'b1; data  = 16'hDCBA; sel  = 2'd0; mode  = 1'b0; en  = 1'b0;
        rst3 = 1'b1; data3 = 12'h321;  sel3 = 2'd0; mode3 = 1'b0; en3 = 1'b0;
        tick(); tick();
        check("rst_z", 32'(z), 0);
        check("rst_ch", 32'(ch), 0);
        check("rst_step", 32'(step), 0);
        check("rst_valid", 32'(valid), 0);

        // Manual select of channel C
        sel = 2'd2; rst = 1'b0; rst3 = 1'b0;
        tick();
        check("man_z", 32'(z), 'hC);
        check("man_ch", 32'(ch), 2);
        check("man_valid", 32'(valid), 1);
        check("man_step", 32'(step), 0);

        // Auto-scan from channel 2
        mode = 1'b1; en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            check($sformatf("scan_ch[%0d]", k), 32'(ch), 32'(exp_ch[k]));
            check($sformatf("scan_step[%0d]", k), 32'(step), 32'(exp_st[k]));
            check($sformatf("scan_z[%0d]", k), 32'(z), 32'(exp_z[k]));
        end

        // Advance to channel 3 (two more dwells)
        repeat (8) tick();
        check("to3_ch", 32'(ch), 3);
        check("to3_step", 32'(step), 1);

        // Freeze with iEn=0 while channel 3 data changes
        en = 1'b0; data = 16'hECBA;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("hold_ch[%0d]", k), 32'(ch), 3);
            check($sformatf("hold_step[%0d]", k), 32'(step), 0);
            check($sformatf("hold_z[%0d]", k), 32'(z), 'hE);
        end

        // Resume; leave manual exactly on the wrap cycle
        en = 1'b1;
        repeat (3) tick();
        check("prewrap_ch", 32'(ch), 3);
        mode = 1'b0; sel = 2'd1;
        tick();
        check("wrapexit_ch", 32'(ch), 1);
        check("wrapexit_step", 32'(step), 0);
        check("wrapexit_z", 32'(z), 'hB);

        // Mid-scan asynchronous reset
        mode = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("arst_z", 32'(z), 0);
        check("arst_ch", 32'(ch), 0);
        check("arst_step", 32'(step), 0);
        check("arst_valid", 32'(valid), 0);
        tick();
        rst = 1'b0;
        tick();
        check("restart_ch", 32'(ch), 0);
        check("restart_z", 32'(z), 'hA);
        check("restart_valid", 32'(valid), 1);
        check("restart_step", 32'(step), 0);

        // Three-channel instance, DIV=1: advances every cycle, wraps 2->0
        check("c3_idle_ch", 32'(ch3), 0);
        mode3 = 1'b1; en3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("c3_ch[%0d]", k), 32'(ch3), 32'(exp_ch3[k]));
            check($sformatf("c3_step[%0d]", k), 32'(step3), 32'(exp_st3[k]));
            check($sformatf("c3_z[%0d]", k), 32'(z3), 32'(exp_z3[k]));
        end

        // Out-of-range manual index holds the channel, valid index loads
        mode3 = 1'b0; sel3 = 2'd3;
        tick();
        check("c3_sel3_exit_ch", 32'(ch3), 1);
        check("c3_sel3_exit_step", 32'(step3), 0);
        tick();
        check("c3_sel3_hold_ch", 32'(ch3), 1);
        check("c3_sel3_hold_z", 32'(z3), 2);
        sel3 = 2'd2;
        tick();
        check("c3_sel2_ch", 32'(ch3), 2);
        check("c3_sel2_z", 32'(z3), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/selector_scan.md
SELECTOR_SCAN -- requirements
Module: selector_scan

Interface
REQ-001 Parameter WIDTH, default 4, bit width of each data channel.
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16; need not be a power of two).
REQ-003 Parameter DIV, default 4, clock cycles per channel dwell in scan mode (1..65535).
REQ-004 Derived constant SEL_W = max(1, ceil(log2(CHANNELS))).
REQ-005 Port: iClk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port: iRst  input  1  reset, asynchronous, active-high.
REQ-007 Port: iData  input  CHANNELS*WIDTH  flat channel bus; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port: iSel  input  SEL_W  channel index used in manual mode.
REQ-009 Port: iMode  input  1  mode select: 0 = manual, 1 = auto-scan.
REQ-010 Port: iEn  input  1  scan advance enable; 0 freezes the dwell counter and channel.
REQ-011 Port: oZ  output  WIDTH  registered data of the current channel.
REQ-012 Port: oCh  output  SEL_W  index of the channel currently driving oZ.
REQ-013 Port: oStep  output  1  one-cycle pulse, coincident with the cycle in which oCh first shows a scan-advanced channel.
REQ-014 Port: oValid  output  1  high once oZ holds data sampled after reset.

Function
REQ-015 The block SHALL hold a two-state FSM: MANUAL and SCAN; state follows iMode with one cycle of latency.
REQ-016 In MANUAL, ch SHALL load iSel each cycle when iSel < CHANNELS; if iSel >= CHANNELS, ch SHALL hold its previous value.
REQ-017 MANUAL->SCAN transition SHALL keep ch unchanged and clear the dwell counter to 0.
REQ-018 In SCAN with iEn=1, the dwell counter SHALL count 0..DIV-1; at DIV-1 it SHALL wrap to 0 and ch SHALL advance by 1.
REQ-019 ch advance SHALL wrap CHANNELS-1 -> 0 exactly (no visit to unused indices).
REQ-020 In SCAN with iEn=0, counter and ch SHALL hold; oZ SHALL continue to track iData of the held channel.
REQ-021 SCAN->MANUAL transition SHALL load ch from iSel (subject to REQ-016) on the transition cycle and clear the counter.
REQ-022 oZ SHALL equal iData slice of ch as registered on the same edge that updates ch, i.e., oZ and oCh are always consistent; latency iData->oZ is one cycle.
REQ-023 oStep SHALL be 1 for exactly one cycle per scan advance and 0 in MANUAL and on mode transitions.
REQ-024 With DIV=1, ch SHALL advance every cycle in SCAN with iEn=1, and oStep SHALL stay high.
REQ-025 An iMode change coinciding with a counter wrap SHALL take the mode transition and suppress the advance and oStep.

Reset
REQ-026 While iRst=1: state=MANUAL, ch=0, counter=0, oZ=0, oCh=0, oStep=0, oValid=0, asynchronously.
REQ-027 oValid SHALL rise on the first rising edge after iRst deasserts and stay high until the next reset.
REQ-028 Reset asserted mid-scan SHALL abandon the dwell immediately; after release, operation restarts per REQ-015 from ch=0.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (MANUAL=0, SCAN=1) and the SEL_W computation function.
REQ-030 One sub-module, selector_dwell_cnt (counter with enable, clear and wrap pulse), SHALL implement the dwell counter; mux and FSM remain in selector_scan.

Verification (WIDTH=4, CHANNELS=4, DIV=4, channels 0..3 = A,B,C,D)
REQ-031 Reset then iMode=0, iSel=2 -> after 1 edge oZ=C, oCh=2, oValid=1, oStep=0.
REQ-032 iMode=1, iEn=1 from ch=2 -> oCh sequence 2 (4 cycles), 3 (4), 0 (4), 1; oStep pulses every 4 cycles; oZ C,D,A,B.
REQ-033 In SCAN, iEn=0 for 10 cycles, channel 3 data changed D->E -> oCh stays 3, oZ becomes E after 1 cycle, no oStep.
REQ-034 CHANNELS=3 instance, SCAN -> oCh 0,1,2,0 with no index 3; manual iSel=3 -> oCh holds previous value.
REQ-035 iMode 1->0 on the wrap cycle with iSel=1 -> oCh=1, no oStep; iRst pulse mid-scan -> all outputs 0 immediately, oValid 0.
